// File: rtl/credit_output_port.sv
// Router output port: a small local flit queue that drains onto the outbound link
// only while downstream credits remain. The neighbour returns one credit per freed slot.
module credit_output_port #(
  parameter int WIDTH   = 16,
  parameter int CREDITS = 4,
  parameter int QDEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         port_en,
  input  logic                         inc_credit_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         send_data,
  output logic                         full,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic                         ovf_err,
  output logic                         credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int NW = $clog2(QDEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [NW-1:0] QFULL    = NW'(QDEPTH);
  localparam logic [CW-1:0] CR_MAX   = CW'(CREDITS);

  logic [WIDTH-1:0] mem_q [QDEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    cnt_q,    cnt_d;
  logic [CW-1:0]    cr_q,     cr_d;
  logic             full_q,   full_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             send_q,   send_d;
  logic             ovf_q,    ovf_d;
  logic             cerr_q,   cerr_d;

  logic enq;
  logic deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Both decisions use pre-edge state, so a full queue rejects port_en even if it drains this cycle.
  assign enq = port_en && !full_q;
  assign deq = (cnt_q != '0) && (cr_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    cr_d     = cr_q;
    data_d   = data_q;
    send_d   = 1'b0;
    ovf_d    = ovf_q | (port_en & full_q);
    cerr_d   = cerr_q;

    if (enq) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (deq) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
      data_d   = mem_q[rd_ptr_q];
      send_d   = 1'b1;
    end

    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == QFULL);

    // A returned credit with the counter already at its maximum is a protocol error; saturate.
    case ({inc_credit_i, deq})
      2'b10: begin
        if (cr_q == CR_MAX) begin
          cerr_d = 1'b1;
        end else begin
          cr_d = cr_q + CW'(1);
        end
      end
      2'b01:   cr_d = cr_q - CW'(1);
      default: cr_d = cr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cr_q     <= CR_MAX;
      full_q   <= 1'b0;
      data_q   <= '0;
      send_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cr_q     <= cr_d;
      full_q   <= full_d;
      data_q   <= data_d;
      send_q   <= send_d;
      ovf_q    <= ovf_d;
      cerr_q   <= cerr_d;
    end
  end

  assign data_o       = data_q;
  assign send_data    = send_q;
  assign full         = full_q;
  assign credit_cnt_o = cr_q;
  assign ovf_err      = ovf_q;
  assign credit_err   = cerr_q;

endmodule

// File: tb/tb_credit_output_port.sv
// Bench for credit_output_port: accepted flits go into a scoreboard queue and are
// matched in order against each send_data pulse; a small port model tracks credits and occupancy.
module tb_credit_output_port;

  localparam int WIDTH   = 16;
  localparam int CREDITS = 4;
  localparam int QDEPTH  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             port_en = 1'b0;
  logic             inc_credit_i = 1'b0;
  logic [WIDTH-1:0] data_o;
  logic             send_data;
  logic             full;
  logic [2:0]       credit_cnt_o;
  logic             ovf_err;
  logic             credit_err;

  credit_output_port #(.WIDTH(WIDTH), .CREDITS(CREDITS), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .port_en      (port_en),
    .inc_credit_i (inc_credit_i),
    .data_o       (data_o),
    .send_data    (send_data),
    .full         (full),
    .credit_cnt_o (credit_cnt_o),
    .ovf_err      (ovf_err),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] sb[$];
  int               m_cnt;
  int               m_cr;
  bit               m_ovf;
  bit               m_cerr;
  logic [WIDTH-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt  = 0;
    m_cr   = CREDITS;
    m_ovf  = 1'b0;
    m_cerr = 1'b0;
    m_data = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".full"},   full,         (m_cnt == QDEPTH));
    check({tag, ".credit"}, credit_cnt_o, m_cr);
    check({tag, ".ovf"},    ovf_err,      m_ovf);
    check({tag, ".cerr"},   credit_err,   m_cerr);
    check({tag, ".data"},   data_o,       m_data);
  endtask

  // One clock: drive inputs, advance the model on pre-edge state, then check after the edge.
  task automatic cycle(input bit en, input logic [WIDTH-1:0] d, input bit inc);
    bit deq, enq;
    port_en      = en;
    data_i       = d;
    inc_credit_i = inc;
    deq = (m_cnt > 0) && (m_cr > 0);
    enq = en && (m_cnt != QDEPTH);
    if (en && !enq) m_ovf = 1'b1;
    if (enq) sb.push_back(d);
    m_cnt = m_cnt + int'(enq) - int'(deq);
    if (inc && !deq && m_cr == CREDITS) m_cerr = 1'b1;
    else m_cr = m_cr + int'(inc) - int'(deq);
    @(posedge clk);
    #1;
    check("send", send_data, deq);
    if (send_data) begin
      check("sb_avail", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) m_data = sb.pop_front();
    end
    check_state("cyc");
  endtask

  task automatic idle(input int n, input bit inc);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, inc);
  endtask

  // Route-logic style enqueue: port_en only while the port reports not full.
  task automatic send_flits(input int first, input int n);
    int nxt;
    int budget;
    nxt = first;
    budget = 0;
    while (nxt < first + n && budget < 60) begin
      if (!full) begin
        cycle(1'b1, WIDTH'(nxt), 1'b0);
        nxt++;
      end else begin
        cycle(1'b0, '0, 1'b0);
      end
      budget++;
    end
    check("enq_budget", nxt, first + n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check("rst.send", send_data, 1'b0);
    check_state("rst");
    rst = 1'b1;

    // Single flit: visible one edge after the enqueue edge.
    cycle(1'b1, 16'hA5A5, 1'b0);
    check("t1.early", send_data, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("t1.send", send_data, 1'b1);
    check("t1.data", data_o, 16'hA5A5);
    check("t1.cr", credit_cnt_o, 3);
    cycle(1'b0, '0, 1'b1);

    // Six flits, no credits returned: four go out, two are held.
    send_flits(1, 6);
    idle(3, 1'b0);
    check("t2.cr0", credit_cnt_o, 0);
    check("t2.full", full, 1'b1);
    check("t2.held", sb.size(), 2);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    idle(3, 1'b0);
    check("t2.drained", sb.size(), 0);
    check("t2.cr_end", credit_cnt_o, 0);

    // Zero credits with a full queue while port_en keeps asserting.
    cycle(1'b1, 16'h0007, 1'b0);
    cycle(1'b1, 16'h0008, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(9 + i), (i % 2) == 0);
    idle(2, 1'b0);
    check("t3.cr0", credit_cnt_o, 0);
    check("t3.ovf", ovf_err, 1'b1);
    cycle(1'b0, '0, 1'b1);
    idle(2, 1'b0);
    idle(4, 1'b1);
    check("t3.cr_full", credit_cnt_o, 4);

    // Credit return with the counter already at maximum.
    cycle(1'b0, '0, 1'b1);
    check("t4.cr_sat", credit_cnt_o, 4);
    check("t4.cerr", credit_err, 1'b1);
    idle(3, 1'b0);
    check("t4.cerr_sticky", credit_err, 1'b1);

    // Asynchronous reset with two flits held.
    send_flits(32, 6);
    idle(2, 1'b0);
    check("t5.held", sb.size(), 2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("t5.send", send_data, 1'b0);
    check_state("t5");
    #3;
    rst = 1'b1;
    idle(4, 1'b0);
    check("t5.cr", credit_cnt_o, 4);
    cycle(1'b1, 16'h5555, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("t5.new", data_o, 16'h5555);
    cycle(1'b0, '0, 1'b1);

    // Random traffic with random credit returns.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1) == 1, WIDTH'($urandom), $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, m_cr < CREDITS);
    check("final.sb_empty", sb.size(), 0);
    check("final.cr", credit_cnt_o, CREDITS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
